// File: rtl/mem_stage_lsu_if.sv
// rtl/mem_stage_lsu_if.sv - data-memory request/response bus between the LSU and dmem
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_be;
  logic                mem_rsp_valid;
  logic [XLEN-1:0]     mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_addr, mem_wdata, mem_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_addr, mem_wdata, mem_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEMORY-stage load/store unit with byte lanes, dmem handshake and flush drain
// Optional: MISALIGN_EX_EN turns misaligned/unsupported accesses into load/store exceptions.
module mem_stage_lsu #(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int EX_W       = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [4:0]            opcode_in,
  input  logic [2:0]            funct_in,
  input  logic [XLEN-1:0]       result_in,
  input  logic [ADDR_W-1:0]     addr_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [EX_W-1:0]       exception_in,
  input  logic                  exception_in_valid,
  input  logic                  flush,
  input  logic                  stall_in,
  output logic                  stall_out,
  output logic                  out_valid,
  output logic [4:0]            opcode_out,
  output logic [XLEN-1:0]       result_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [EX_W-1:0]       exception_out,
  output logic                  exception_out_valid,
  mem_stage_lsu_if.master       dmem
);
  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_HOLD, S_DRAIN} state_t;
  state_t state, state_n;

  logic                  is_load, is_mem;
  logic                  unsupported, misal_trap;
  logic [1:0]            eff_size;
  logic [OFF_W-1:0]      off_raw, size_m1, off_al;
  logic [BE_W-1:0]       be_mask, be_calc;
  logic [XLEN-1:0]       wdata_calc;

  logic [4:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [1:0]            size_q;
  logic                  zext_q, we_q;
  logic [OFF_W-1:0]      off_q;
  logic [XLEN-1:0]       res_q, wdata_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [BE_W-1:0]       be_q;

  logic [XLEN-1:0]       shifted, ext_mask, ld_data;
  logic                  sign_bit;

  logic                  cap, buf_load, fin_valid, fin_exv;
  logic [4:0]            fin_op;
  logic [XLEN-1:0]       fin_res;
  logic [REG_ADDR_W-1:0] fin_rd;
  logic [EX_W-1:0]       fin_ex;

  assign is_load = (opcode_in == 5'b00000);
  assign is_mem  = is_load || (opcode_in == 5'b01000);

  // Request decode; an unsupported size is handled as a word access when not trapping.
  always_comb begin
    unsupported = (XLEN == 32) && (funct_in[1:0] == 2'b11);
    eff_size    = unsupported ? 2'b10 : funct_in[1:0];
    off_raw     = addr_in[OFF_W-1:0];
    case (eff_size)
      2'b00:   begin size_m1 = '0;        be_mask = BE_W'(8'h01); end
      2'b01:   begin size_m1 = OFF_W'(1); be_mask = BE_W'(8'h03); end
      2'b10:   begin size_m1 = OFF_W'(3); be_mask = BE_W'(8'h0F); end
      default: begin size_m1 = OFF_W'(7); be_mask = BE_W'(8'hFF); end
    endcase
    off_al  = off_raw & ~size_m1;
    be_calc = be_mask << off_al;
    case (eff_size)
      2'b00:   wdata_calc = {BE_W{result_in[7:0]}};
      2'b01:   wdata_calc = {(XLEN/16){result_in[15:0]}};
      2'b10:   wdata_calc = {(XLEN/32){result_in[31:0]}};
      default: wdata_calc = result_in;
    endcase
  end

`ifdef MISALIGN_EX_EN
  assign misal_trap = unsupported || (|(off_raw & size_m1));
`else
  assign misal_trap = 1'b0;
`endif

  // Lane extraction and extension of the returned load word.
  always_comb begin
    shifted = dmem.mem_rsp_data >> {off_q, 3'b000};
    case (size_q)
      2'b00:   begin ext_mask = ~XLEN'(8'hFF);         sign_bit = shifted[7];  end
      2'b01:   begin ext_mask = ~XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
      2'b10:   begin ext_mask = ~XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: begin ext_mask = '0;                    sign_bit = 1'b0;        end
    endcase
    ld_data = (shifted & ~ext_mask) | ((!zext_q && sign_bit) ? ext_mask : '0);
  end

  always_comb begin
    state_n   = state;
    cap       = 1'b0;
    buf_load  = 1'b0;
    fin_valid = 1'b0;
    fin_op    = op_q;
    fin_res   = res_q;
    fin_rd    = rd_q;
    fin_ex    = '0;
    fin_exv   = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid && !stall_in && !flush) begin
          if (exception_in_valid || !is_mem) begin
            fin_valid = 1'b1;
            fin_op    = opcode_in;
            fin_res   = result_in;
            fin_rd    = rd_addr_in;
            fin_ex    = exception_in;
            fin_exv   = exception_in_valid;
          end else if (misal_trap) begin
            fin_valid = 1'b1;
            fin_op    = opcode_in;
            fin_res   = XLEN'(addr_in);
            fin_rd    = rd_addr_in;
            fin_ex    = is_load ? EX_W'(4) : EX_W'(6);
            fin_exv   = 1'b1;
          end else begin
            cap     = 1'b1;
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (dmem.mem_req_ready) begin
          if (we_q) begin
            fin_valid = 1'b1;
            buf_load  = stall_in;
            state_n   = stall_in ? S_HOLD : S_IDLE;
          end else begin
            state_n = S_RESP;
          end
        end
      end
      S_RESP: begin
        // A response coinciding with the flush is already consumed, so no drain is needed.
        if (flush) begin
          state_n = dmem.mem_rsp_valid ? S_IDLE : S_DRAIN;
        end else if (dmem.mem_rsp_valid) begin
          fin_valid = 1'b1;
          fin_res   = ld_data;
          buf_load  = stall_in;
          state_n   = stall_in ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_n = S_IDLE;
        end else if (!stall_in) begin
          fin_valid = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (dmem.mem_rsp_valid) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      size_q  <= '0;
      zext_q  <= 1'b0;
      we_q    <= 1'b0;
      off_q   <= '0;
      res_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      be_q    <= '0;
    end else if (cap) begin
      op_q    <= opcode_in;
      rd_q    <= rd_addr_in;
      size_q  <= eff_size;
      zext_q  <= funct_in[2];
      we_q    <= !is_load;
      off_q   <= off_al;
      res_q   <= result_in;
      wdata_q <= wdata_calc;
      addr_q  <= {addr_in[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      be_q    <= be_calc;
    end else if (buf_load) begin
      res_q <= fin_res;
    end
  end

  // Outputs freeze under a downstream stall; flush still kills out_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid           <= 1'b0;
      opcode_out          <= '0;
      result_out          <= '0;
      rd_addr_out         <= '0;
      exception_out       <= '0;
      exception_out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall_in) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        opcode_out          <= fin_op;
        result_out          <= fin_res;
        rd_addr_out         <= fin_rd;
        exception_out       <= fin_ex;
        exception_out_valid <= fin_exv;
      end
    end
  end

  assign stall_out          = (state != S_IDLE);
  assign dmem.mem_req_valid = (state == S_REQ) && !flush;
  assign dmem.mem_req_we    = we_q;
  assign dmem.mem_addr      = addr_q;
  assign dmem.mem_wdata     = wdata_q;
  assign dmem.mem_be        = be_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - table-driven and scoreboarded bench for mem_stage_lsu (XLEN 32)
module tb_mem_stage_lsu;
  localparam logic [4:0] LD  = 5'b00000;
  localparam logic [4:0] ST  = 5'b01000;
  localparam logic [4:0] ALU = 5'b01100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [4:0]  opcode_in = '0;
  logic [2:0]  funct_in = '0;
  logic [31:0] result_in = '0;
  logic [31:0] addr_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic [3:0]  exception_in = '0;
  logic        exception_in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall_in = 1'b0;
  logic        stall_out, out_valid, exception_out_valid;
  logic [4:0]  opcode_out, rd_addr_out;
  logic [31:0] result_out;
  logic [3:0]  exception_out;

  mem_stage_lsu_if #(.XLEN(32), .ADDR_W(32)) dmem ();

  mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .REG_ADDR_W(5), .EX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .opcode_in(opcode_in),
    .funct_in(funct_in), .result_in(result_in), .addr_in(addr_in),
    .rd_addr_in(rd_addr_in), .exception_in(exception_in),
    .exception_in_valid(exception_in_valid), .flush(flush), .stall_in(stall_in),
    .stall_out(stall_out), .out_valid(out_valid), .opcode_out(opcode_out),
    .result_out(result_out), .rd_addr_out(rd_addr_out), .exception_out(exception_out),
    .exception_out_valid(exception_out_valid), .dmem(dmem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  fn;
    logic [31:0] data;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        exv;
    logic [3:0]  ex;
    logic [31:0] rsp;
    logic        mem;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] res;
    logic        chk_res;
    logic        oexv;
    logic [3:0]  oex;
  } vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] res;
    logic        chk_res;
    logic [4:0]  rd;
    logic        exv;
    logic [3:0]  ex;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] fn, input logic [31:0] data,
                              input logic [31:0] addr, input logic [4:0] rd, input logic exv,
                              input logic [3:0] ex, input logic [31:0] rsp, input logic mem,
                              input logic [3:0] be, input logic [31:0] maddr, input logic [31:0] wdata,
                              input logic chk_wdata, input logic [31:0] res, input logic chk_res,
                              input logic oexv, input logic [3:0] oex);
    vec_t v;
    v.op = op; v.fn = fn; v.data = data; v.addr = addr; v.rd = rd; v.exv = exv; v.ex = ex;
    v.rsp = rsp; v.mem = mem; v.be = be; v.maddr = maddr; v.wdata = wdata;
    v.chk_wdata = chk_wdata; v.res = res; v.chk_res = chk_res; v.oexv = oexv; v.oex = oex;
    return v;
  endfunction

  // Scoreboard side: every out_valid must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected none at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_opcode", 64'(opcode_out), 64'(e.op));
        chk("out_rd", 64'(rd_addr_out), 64'(e.rd));
        chk("out_exv", 64'(exception_out_valid), 64'(e.exv));
        chk("out_ex", 64'(exception_out), 64'(e.ex));
        if (e.chk_res) chk("out_result", 64'(result_out), 64'(e.res));
      end
    end
  end

  task automatic start(input vec_t v, input bit push);
    exp_t e;
    @(negedge clk);
    opcode_in = v.op; funct_in = v.fn; result_in = v.data; addr_in = v.addr;
    rd_addr_in = v.rd; exception_in = v.ex; exception_in_valid = v.exv; in_valid = 1'b1;
    if (push) begin
      e.op = v.op; e.res = v.res; e.chk_res = v.chk_res; e.rd = v.rd; e.exv = v.oexv; e.ex = v.oex;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    exception_in_valid = 1'b0;
  endtask

  task automatic check_req(input vec_t v, input string tag);
    chk({tag, "_req_valid"}, 64'(dmem.mem_req_valid), 64'd1);
    chk({tag, "_addr"}, 64'(dmem.mem_addr), 64'(v.maddr));
    chk({tag, "_be"}, 64'(dmem.mem_be), 64'(v.be));
    chk({tag, "_we"}, 64'(dmem.mem_req_we), 64'(v.op == ST));
    if (v.chk_wdata) chk({tag, "_wdata"}, 64'(dmem.mem_wdata), 64'(v.wdata));
  endtask

  task automatic run(input vec_t v, input int rdly, input int sdly, input string tag);
    start(v, 1'b1);
    if (!v.mem) begin
      chk({tag, "_no_req"}, 64'(dmem.mem_req_valid), 64'd0);
      chk({tag, "_stall_out"}, 64'(stall_out), 64'd0);
      chk({tag, "_done"}, 64'(out_valid), 64'd1);
    end else begin
      for (int c = 0; c < rdly; c++) begin
        check_req(v, tag);
        chk({tag, "_stall_wait"}, 64'(stall_out), 64'd1);
        @(negedge clk);
      end
      check_req(v, tag);
      dmem.mem_req_ready = 1'b1;
      @(negedge clk);
      dmem.mem_req_ready = 1'b0;
      if (v.op == LD) begin
        for (int c = 0; c < sdly; c++) begin
          chk({tag, "_early"}, 64'(out_valid), 64'd0);
          @(negedge clk);
        end
        dmem.mem_rsp_valid = 1'b1;
        dmem.mem_rsp_data  = v.rsp;
        @(negedge clk);
        dmem.mem_rsp_valid = 1'b0;
      end
      chk({tag, "_done"}, 64'(out_valid), 64'd1);
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    dmem.mem_req_ready = 1'b0;
    dmem.mem_rsp_valid = 1'b0;
    dmem.mem_rsp_data  = '0;

    vecs.push_back(mk(ALU, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 1, 0, 0));
    vecs.push_back(mk(LD, 3'b000, 0, 32'h103, 5'd1, 0, 0, 32'h80FF_FF00, 1, 4'b1000, 32'h100, 0, 0, 32'hFFFF_FF80, 1, 0, 0));
    vecs.push_back(mk(LD, 3'b100, 0, 32'h103, 5'd2, 0, 0, 32'h80FF_FF00, 1, 4'b1000, 32'h100, 0, 0, 32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(ST, 3'b001, 32'hABCD, 32'h102, 5'd0, 0, 0, 0, 1, 4'b1100, 32'h100, 32'hABCD_ABCD, 1, 0, 0, 0, 0));
    vecs.push_back(mk(LD, 3'b001, 0, 32'h102, 5'd7, 0, 0, 32'h8001_1234, 1, 4'b1100, 32'h100, 0, 0, 32'hFFFF_8001, 1, 0, 0));
    vecs.push_back(mk(LD, 3'b101, 0, 32'h100, 5'd8, 0, 0, 32'h1234_F00D, 1, 4'b0011, 32'h100, 0, 0, 32'h0000_F00D, 1, 0, 0));
    vecs.push_back(mk(LD, 3'b010, 0, 32'h104, 5'd3, 0, 0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h104, 0, 0, 32'hDEAD_BEEF, 1, 0, 0));
    vecs.push_back(mk(ST, 3'b000, 32'h5A, 32'h101, 5'd0, 0, 0, 0, 1, 4'b0010, 32'h100, 32'h5A5A_5A5A, 1, 0, 0, 0, 0));
    vecs.push_back(mk(ST, 3'b010, 32'hCAFE_F00D, 32'h208, 5'd0, 0, 0, 0, 1, 4'b1111, 32'h208, 32'hCAFE_F00D, 1, 0, 0, 0, 0));
    vecs.push_back(mk(LD, 3'b010, 32'h77, 32'h100, 5'd9, 1, 4'd3, 0, 0, 0, 0, 0, 0, 32'h77, 1, 1, 4'd3));
`ifdef MISALIGN_EX_EN
    vecs.push_back(mk(LD, 3'b010, 0, 32'h102, 5'd10, 0, 0, 0, 0, 0, 0, 0, 0, 32'h102, 1, 1, 4'd4));
    vecs.push_back(mk(ST, 3'b010, 32'h99, 32'h101, 5'd11, 0, 0, 0, 0, 0, 0, 0, 0, 32'h101, 1, 1, 4'd6));
    vecs.push_back(mk(LD, 3'b001, 0, 32'h103, 5'd12, 0, 0, 0, 0, 0, 0, 0, 0, 32'h103, 1, 1, 4'd4));
`else
    vecs.push_back(mk(LD, 3'b010, 0, 32'h102, 5'd10, 0, 0, 32'h1122_3344, 1, 4'b1111, 32'h100, 0, 0, 32'h1122_3344, 1, 0, 0));
    vecs.push_back(mk(ST, 3'b010, 32'h99, 32'h101, 5'd11, 0, 0, 0, 1, 4'b1111, 32'h100, 32'h99, 1, 0, 0, 0, 0));
    vecs.push_back(mk(LD, 3'b001, 0, 32'h103, 5'd12, 0, 0, 32'h7FFF_0000, 1, 4'b1100, 32'h100, 0, 0, 32'h0000_7FFF, 1, 0, 0));
`endif

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_out", 64'(stall_out), 64'd0);
    chk("rst_req_valid", 64'(dmem.mem_req_valid), 64'd0);
    chk("rst_result", 64'(result_out), 64'd0);
    chk("rst_be", 64'(dmem.mem_be), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run(vecs[i], i % 2, i % 3, $sformatf("vec%0d", i));

    // Store with ready held low for three cycles.
    v = mk(ST, 3'b010, 32'h0BAD_CAFE, 32'h30C, 5'd0, 0, 0, 0, 1, 4'b1111, 32'h30C, 32'h0BAD_CAFE, 1, 0, 0, 0, 0);
    run(v, 3, 0, "st_wait3");

    // Flush while waiting for the load response: response must be drained silently.
    v = mk(LD, 3'b010, 0, 32'h100, 5'd4, 0, 0, 0, 1, 4'b1111, 32'h100, 0, 0, 0, 0, 0, 0);
    start(v, 1'b0);
    dmem.mem_req_ready = 1'b1;
    @(negedge clk);
    dmem.mem_req_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("drain_stall1", 64'(stall_out), 64'd1);
    chk("drain_ov1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("drain_stall2", 64'(stall_out), 64'd1);
    dmem.mem_rsp_valid = 1'b1;
    dmem.mem_rsp_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem.mem_rsp_valid = 1'b0;
    chk("drain_idle", 64'(stall_out), 64'd0);
    chk("drain_ov2", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Flush before the request is accepted abandons it.
    start(v, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_stall", 64'(stall_out), 64'd0);
    chk("flush_req_valid", 64'(dmem.mem_req_valid), 64'd0);
    @(negedge clk);

    // Flush together with in_valid: not accepted.
    @(negedge clk);
    opcode_in = ALU; result_in = 32'h55; rd_addr_in = 5'd6; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_in_stall", 64'(stall_out), 64'd0);
    chk("flush_in_ov", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Response arrives under a two-cycle downstream stall.
    v = mk(LD, 3'b000, 0, 32'h109, 5'd13, 0, 0, 0, 1, 4'b0010, 32'h108, 0, 0, 32'hFFFF_FFF0, 1, 0, 0);
    start(v, 1'b1);
    check_req(v, "hold");
    dmem.mem_req_ready = 1'b1;
    @(negedge clk);
    dmem.mem_req_ready = 1'b0;
    dmem.mem_rsp_valid = 1'b1;
    dmem.mem_rsp_data  = 32'h1234_F0AA;
    stall_in = 1'b1;
    @(negedge clk);
    dmem.mem_rsp_valid = 1'b0;
    chk("hold_stall_out", 64'(stall_out), 64'd1);
    chk("hold_ov1", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("hold_ov2", 64'(out_valid), 64'd0);
    stall_in = 1'b0;
    @(negedge clk);
    chk("hold_done", 64'(out_valid), 64'd1);
    chk("hold_idle", 64'(stall_out), 64'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a request.
    v = mk(LD, 3'b010, 0, 32'h200, 5'd14, 0, 0, 0, 1, 4'b1111, 32'h200, 0, 0, 0, 0, 0, 0);
    start(v, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_stall_out", 64'(stall_out), 64'd0);
    chk("arst_req_valid", 64'(dmem.mem_req_valid), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
